// File: rtl/wishbone_master_if.sv
// CPU-side Wishbone classic initiator: one CPU request becomes one
// single-beat bus cycle, with pipeline stall, flush and timeout abort.
module wishbone_master_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam bit         TO_EN   = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        drop;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = we_q;
        sel_d       = sel_q;
        rd_buf_d    = rd_buf_q;
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
        drop        = 1'b0;
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
        unique case (state_q)
            IDLE: begin
                stall_req_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    cyc_d   = 1'b1;
                    addr_d  = cpu_addr_i;
                    data_d  = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // ack wins over flush and timeout in the same cycle
                if (wishbone_ack_i) begin
                    drop       = 1'b1;
                    rd_buf_d   = wishbone_data_i;
                    cpu_data_o = we_q ? '0 : wishbone_data_i;
                    state_d    = stall_i ? WAIT_STALL : IDLE;
                end else if (flush_i) begin
                    drop     = 1'b1;
                    rd_buf_d = '0;
                    state_d  = WAIT_STALL;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    drop      = 1'b1;
                    rd_buf_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = WAIT_STALL;
                end else begin
                    stall_req_o = 1'b1;
                    cnt_d       = cnt_q + 8'd1;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop) begin
            cyc_d  = 1'b0;
            addr_d = '0;
            data_d = '0;
            we_d   = 1'b0;
            sel_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wishbone_cyc_o  = cyc_q;
    assign wishbone_stb_o  = cyc_q;
    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = data_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_wishbone_master_if.sv
// Scoreboard bench for wishbone_master_if with a small delayed-ack slave.
module tb_wishbone_master_if;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } bus_t;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] cpu_data_o;
    logic        stall;
    logic        flush;
    logic        stall_req;
    logic        bus_err;
    logic [31:0] wb_addr;
    logic [31:0] wb_dout;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        stb;
    logic        cyc;
    logic [31:0] wb_din;
    logic        ack;

    int errors = 0;
    int checks = 0;

    bus_t        q_bus[$];
    logic [31:0] q_ack[$];
    logic [31:0] q_err[$];

    int          ack_delay;
    int          busy_n;
    logic [31:0] slv_rdata;
    logic [31:0] mem [16];

    logic        mon_prev;
    bus_t        mon_cur;

    wishbone_master_if #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_ce_i        (ce),
        .cpu_addr_i      (addr_i),
        .cpu_data_i      (data_i),
        .cpu_we_i        (we_i),
        .cpu_sel_i       (sel_i),
        .cpu_data_o      (cpu_data_o),
        .stall_i         (stall),
        .flush_i         (flush),
        .stall_req_o     (stall_req),
        .bus_err_o       (bus_err),
        .wishbone_addr_o (wb_addr),
        .wishbone_data_o (wb_dout),
        .wishbone_we_o   (wb_we),
        .wishbone_sel_o  (wb_sel),
        .wishbone_stb_o  (stb),
        .wishbone_cyc_o  (cyc),
        .wishbone_data_i (wb_din),
        .wishbone_ack_i  (ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Slave: acks in the ack_delay-th cycle of each strobe (never if <= 0)
    initial begin
        ack    = 1'b0;
        wb_din = '0;
        busy_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stb && !ack) begin
                busy_n++;
                if (ack_delay > 0 && busy_n == ack_delay) begin
                    ack    = 1'b1;
                    wb_din = slv_rdata;
                    if (wb_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wb_sel[b]) mem[wb_addr[5:2]][b*8 +: 8] = wb_dout[b*8 +: 8];
                        end
                    end
                end
            end else begin
                ack    = 1'b0;
                busy_n = 0;
                wb_din = '0;
            end
        end
    end

    // Monitor: pops expectations when the DUT starts a cycle, acks or errors
    initial begin
        mon_prev = 1'b0;
        mon_cur  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 1'b0;
                continue;
            end
            if (stb || cyc) chk("cyc_eq_stb", 32'(cyc), 32'(stb));
            if (stb) begin
                if (!mon_prev) begin
                    if (q_bus.size() == 0) chk("bus_unexpected", 32'(stb), 32'd0);
                    else mon_cur = q_bus.pop_front();
                end
                chk("bus_addr", wb_addr, mon_cur.addr);
                chk("bus_data", wb_dout, mon_cur.data);
                chk("bus_ctl", 32'({wb_we, wb_sel}), 32'({mon_cur.we, mon_cur.sel}));
                if (ack) begin
                    if (q_ack.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
                    else chk("ack_cpu_data", cpu_data_o, q_ack.pop_front());
                    chk("ack_stall_req", 32'(stall_req), 32'd0);
                end
            end
            if (bus_err) begin
                if (q_err.size() == 0) chk("err_unexpected", 32'(bus_err), 32'd0);
                else chk("err_cpu_data", cpu_data_o, q_err.pop_front());
            end
            mon_prev = stb;
        end
    end

    task automatic issue(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        bus_t e;
        ce     = 1'b1;
        we_i   = w;
        addr_i = a;
        data_i = d;
        sel_i  = s;
        e.addr = a;
        e.data = d;
        e.we   = w;
        e.sel  = s;
        q_bus.push_back(e);
    endtask

    task automatic observe(int n, output int sc, output int rc, output int ec);
        sc = 0;
        rc = 0;
        ec = 0;
        repeat (n) begin
            @(negedge clk);
            if (stb) sc++;
            if (stall_req) rc++;
            if (bus_err) ec++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int sc, rc, ec;
    logic [2:0] pat;

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b0;
        addr_i    = '0;
        data_i    = '0;
        we_i      = 1'b0;
        sel_i     = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        ack_delay = 0;
        slv_rdata = '0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_addr", wb_addr, 32'd0);
        chk("rst_ctl", 32'({wb_we, wb_sel}), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_cpu_data", cpu_data_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // read, ack in third busy cycle
        ack_delay = 3;
        slv_rdata = 32'hDEADBEEF;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        q_ack.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("rd_idle_stall_req", 32'(stall_req), 32'd1);
        step();
        ce = 1'b0;
        observe(6, sc, rc, ec);
        chk("rd_stb_cycles", 32'(sc), 32'd3);
        chk("rd_stall_cycles", 32'(rc), 32'd2);
        step();

        // write of low half-word to word 9
        ack_delay = 2;
        slv_rdata = 32'hFFFF_FFFF;
        issue(1'b1, 32'h0000_0024, 32'h12345678, 4'b0011);
        q_ack.push_back(32'h0);
        step();
        ce = 1'b0;
        observe(4, sc, rc, ec);
        chk("wr_stb_cycles", 32'(sc), 32'd2);
        chk("wr_mem9", mem[9], 32'h0000_5678);
        step();

        // back-to-back with ce held high
        ack_delay = 1;
        slv_rdata = 32'h11112222;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        q_ack.push_back(32'h11112222);
        step();
        issue(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        q_ack.push_back(32'h11112222);
        @(negedge clk);
        pat[2] = stb;
        step();
        @(negedge clk);
        pat[1] = stb;
        chk("b2b_gap_stall_req", 32'(stall_req), 32'd1);
        step();
        ce = 1'b0;
        @(negedge clk);
        pat[0] = stb;
        chk("b2b_stb_pattern", 32'(pat), 32'd5);
        repeat (3) step();

        // ack under external stall; ce stays high but is ignored
        stall     = 1'b1;
        ack_delay = 2;
        slv_rdata = 32'hA5A5A5A5;
        issue(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        q_ack.push_back(32'hA5A5A5A5);
        repeat (3) step();
        repeat (3) begin
            @(negedge clk);
            chk("hold_cpu_data", cpu_data_o, 32'hA5A5A5A5);
            chk("hold_stb", 32'(stb), 32'd0);
            chk("hold_stall_req", 32'(stall_req), 32'd0);
            step();
        end
        stall = 1'b0;
        ce    = 1'b0;
        @(negedge clk);
        chk("hold_last_data", cpu_data_o, 32'hA5A5A5A5);
        step();
        @(negedge clk);
        chk("hold_idle_data", cpu_data_o, 32'd0);
        chk("hold_idle_stb", 32'(stb), 32'd0);
        step();

        // flush in second busy cycle
        ack_delay = 0;
        issue(1'b0, 32'h0000_00C0, 32'h0, 4'hF);
        step();
        ce = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall_req", 32'(stall_req), 32'd0);
        chk("flush_stb_still", 32'(stb), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stb_drop", 32'(stb), 32'd0);
        repeat (2) step();

        // timeout with no ack
        issue(1'b0, 32'h0000_00E0, 32'h0, 4'hF);
        q_err.push_back(32'h0);
        step();
        ce = 1'b0;
        observe(8, sc, rc, ec);
        chk("to_stb_cycles", 32'(sc), 32'd4);
        chk("to_err_pulses", 32'(ec), 32'd1);
        step();

        // asynchronous reset mid-cycle
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        step();
        ce = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stb", 32'(stb), 32'd0);
        chk("arst_cyc", 32'(cyc), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_stb", 32'(stb), 32'd0);
        chk("arst_idle_stall", 32'(stall_req), 32'd0);
        step();
        ack_delay = 1;
        slv_rdata = 32'hCAFEF00D;
        issue(1'b0, 32'h0000_0104, 32'h0, 4'hF);
        q_ack.push_back(32'hCAFEF00D);
        step();
        ce = 1'b0;
        observe(3, sc, rc, ec);
        chk("arst_after_stb", 32'(sc), 32'd1);
        step();

        chk("q_bus_empty", 32'(q_bus.size()), 32'd0);
        chk("q_ack_empty", 32'(q_ack.size()), 32'd0);
        chk("q_err_empty", 32'(q_err.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
